// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 scan-code set 2 decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

endpackage

// File: rtl/ps2_scancode_decoder_set2_to_ascii.sv
// Combinational US-layout lookup from a set 2 code to ASCII; letters always
// come back lowercase so the caller can apply caps-lock and ctrl.
module ps2_set2_to_ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       extended,
    input  logic       shift,
    output logic [7:0] ascii,
    output logic       printable,
    output logic       is_letter
);

    logic [16:0] entry_s;   // {unshifted, shifted, letter}

    // Table lookup; a zero unshifted value marks a non-printable code.
    always_comb begin
        entry_s = 17'h0_0000;
        if (extended) begin
            case (code)
                8'h5A:   entry_s = {8'h0D, 8'h0D, 1'b0};
                8'h4A:   entry_s = {8'h2F, 8'h2F, 1'b0};
                default: entry_s = 17'h0_0000;
            endcase
        end else begin
            case (code)
                8'h1C: entry_s = {8'h61, 8'h61, 1'b1};
                8'h32: entry_s = {8'h62, 8'h62, 1'b1};
                8'h21: entry_s = {8'h63, 8'h63, 1'b1};
                8'h23: entry_s = {8'h64, 8'h64, 1'b1};
                8'h24: entry_s = {8'h65, 8'h65, 1'b1};
                8'h2B: entry_s = {8'h66, 8'h66, 1'b1};
                8'h34: entry_s = {8'h67, 8'h67, 1'b1};
                8'h33: entry_s = {8'h68, 8'h68, 1'b1};
                8'h43: entry_s = {8'h69, 8'h69, 1'b1};
                8'h3B: entry_s = {8'h6A, 8'h6A, 1'b1};
                8'h42: entry_s = {8'h6B, 8'h6B, 1'b1};
                8'h4B: entry_s = {8'h6C, 8'h6C, 1'b1};
                8'h3A: entry_s = {8'h6D, 8'h6D, 1'b1};
                8'h31: entry_s = {8'h6E, 8'h6E, 1'b1};
                8'h44: entry_s = {8'h6F, 8'h6F, 1'b1};
                8'h4D: entry_s = {8'h70, 8'h70, 1'b1};
                8'h15: entry_s = {8'h71, 8'h71, 1'b1};
                8'h2D: entry_s = {8'h72, 8'h72, 1'b1};
                8'h1B: entry_s = {8'h73, 8'h73, 1'b1};
                8'h2C: entry_s = {8'h74, 8'h74, 1'b1};
                8'h3C: entry_s = {8'h75, 8'h75, 1'b1};
                8'h2A: entry_s = {8'h76, 8'h76, 1'b1};
                8'h1D: entry_s = {8'h77, 8'h77, 1'b1};
                8'h22: entry_s = {8'h78, 8'h78, 1'b1};
                8'h35: entry_s = {8'h79, 8'h79, 1'b1};
                8'h1A: entry_s = {8'h7A, 8'h7A, 1'b1};
                8'h45: entry_s = {8'h30, 8'h29, 1'b0};
                8'h16: entry_s = {8'h31, 8'h21, 1'b0};
                8'h1E: entry_s = {8'h32, 8'h40, 1'b0};
                8'h26: entry_s = {8'h33, 8'h23, 1'b0};
                8'h25: entry_s = {8'h34, 8'h24, 1'b0};
                8'h2E: entry_s = {8'h35, 8'h25, 1'b0};
                8'h36: entry_s = {8'h36, 8'h5E, 1'b0};
                8'h3D: entry_s = {8'h37, 8'h26, 1'b0};
                8'h3E: entry_s = {8'h38, 8'h2A, 1'b0};
                8'h46: entry_s = {8'h39, 8'h28, 1'b0};
                8'h0E: entry_s = {8'h60, 8'h7E, 1'b0};
                8'h4E: entry_s = {8'h2D, 8'h5F, 1'b0};
                8'h55: entry_s = {8'h3D, 8'h2B, 1'b0};
                8'h54: entry_s = {8'h5B, 8'h7B, 1'b0};
                8'h5B: entry_s = {8'h5D, 8'h7D, 1'b0};
                8'h5D: entry_s = {8'h5C, 8'h7C, 1'b0};
                8'h4C: entry_s = {8'h3B, 8'h3A, 1'b0};
                8'h52: entry_s = {8'h27, 8'h22, 1'b0};
                8'h41: entry_s = {8'h2C, 8'h3C, 1'b0};
                8'h49: entry_s = {8'h2E, 8'h3E, 1'b0};
                8'h4A: entry_s = {8'h2F, 8'h3F, 1'b0};
                8'h29: entry_s = {8'h20, 8'h20, 1'b0};
                8'h5A: entry_s = {8'h0D, 8'h0D, 1'b0};
                8'h66: entry_s = {8'h08, 8'h08, 1'b0};
                8'h0D: entry_s = {8'h09, 8'h09, 1'b0};
                8'h76: entry_s = {8'h1B, 8'h1B, 1'b0};
                default: entry_s = 17'h0_0000;
            endcase
        end
    end

    assign ascii     = shift ? entry_s[8:1] : entry_s[16:9];
    assign printable = (entry_s[16:9] != 8'h00);
    assign is_letter = entry_s[0];

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder: strips E0/F0/E1 prefixes, tracks shift, ctrl
// and caps-lock, and emits key events plus ASCII for printable makes.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 62500,
    parameter int PAUSE_SKIP     = 7
) (
    input  logic       clk_25mhz,
    input  logic       reset_n,
    input  logic [7:0] keyb_data,
    input  logic       keyb_valid,
    input  logic       keyb_error,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       key_event,
    output logic [7:0] ascii,
    output logic       ascii_valid,
    output logic       shift,
    output logic       ctrl,
    output logic       caps_lock
);

    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SKW = $clog2(PAUSE_SKIP + 1);

    ps2_state_t     state_r, state_nx_s;
    logic [TOW-1:0] timeout_cnt_r;
    logic [SKW-1:0] skip_cnt_r, skip_nx_s;
    logic           timeout_s, complete_s, comp_ext_s, comp_rel_s, emit_ascii_s;
    logic           lshift_r, rshift_r, lctrl_r, rctrl_r, caps_held_r;
    logic           lshift_nx_s, rshift_nx_s, lctrl_nx_s, rctrl_nx_s;
    logic           caps_held_nx_s, caps_nx_s;
    logic [7:0]     map_ascii_s, ascii_nx_s;
    logic           map_printable_s, map_letter_s;

    assign timeout_s = (state_r != ST_IDLE) && (timeout_cnt_r == TOW'(TIMEOUT_CYCLES - 1));

    // State and Pause skip counter registers.
    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            skip_cnt_r <= {SKW{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            skip_cnt_r <= skip_nx_s;
        end
    end

    // Idle-time counter; restarts on every byte and whenever the FSM rests in IDLE.
    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            timeout_cnt_r <= {TOW{1'b0}};
        end else if ((state_nx_s == ST_IDLE) || keyb_valid || keyb_error) begin
            timeout_cnt_r <= {TOW{1'b0}};
        end else begin
            timeout_cnt_r <= timeout_cnt_r + TOW'(1);
        end
    end

    // Next-state logic; a receiver error outranks a byte arriving in the same cycle.
    always_comb begin
        state_nx_s = state_r;
        skip_nx_s  = skip_cnt_r;
        if (keyb_error) begin
            state_nx_s = ST_IDLE;
            skip_nx_s  = {SKW{1'b0}};
        end else if (keyb_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (keyb_data == PS2_EXT) begin
                        state_nx_s = ST_EXT;
                    end else if (keyb_data == PS2_BRK) begin
                        state_nx_s = ST_BRK;
                    end else if (keyb_data == PS2_PAUSE) begin
                        state_nx_s = ST_SKIP;
                        skip_nx_s  = SKW'(PAUSE_SKIP);
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (keyb_data == PS2_BRK) begin
                        state_nx_s = ST_EXT_BRK;
                    end else if (keyb_data == PS2_EXT) begin
                        state_nx_s = ST_EXT;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_SKIP: begin
                    if (skip_cnt_r <= SKW'(1)) begin
                        state_nx_s = ST_IDLE;
                        skip_nx_s  = {SKW{1'b0}};
                    end else begin
                        state_nx_s = ST_SKIP;
                        skip_nx_s  = skip_cnt_r - SKW'(1);
                    end
                end
                ST_BRK:     state_nx_s = ST_IDLE;
                ST_EXT_BRK: state_nx_s = ST_IDLE;
                default:    state_nx_s = ST_IDLE;
            endcase
        end else if (timeout_s) begin
            state_nx_s = ST_IDLE;
            skip_nx_s  = {SKW{1'b0}};
        end else begin
            state_nx_s = state_r;
        end
    end

    // Sequence completion decode for the byte being accepted this cycle.
    always_comb begin
        complete_s = 1'b0;
        comp_ext_s = 1'b0;
        comp_rel_s = 1'b0;
        if (keyb_valid && !keyb_error) begin
            case (state_r)
                ST_IDLE: complete_s = (keyb_data != PS2_EXT) && (keyb_data != PS2_BRK) &&
                                      (keyb_data != PS2_PAUSE);
                ST_EXT: begin
                    complete_s = (keyb_data != PS2_EXT) && (keyb_data != PS2_BRK);
                    comp_ext_s = 1'b1;
                end
                ST_BRK: begin
                    complete_s = 1'b1;
                    comp_rel_s = 1'b1;
                end
                ST_EXT_BRK: begin
                    complete_s = 1'b1;
                    comp_ext_s = 1'b1;
                    comp_rel_s = 1'b1;
                end
                default: complete_s = 1'b0;
            endcase
        end else begin
            complete_s = 1'b0;
        end
    end

    // Modifier next state; caps_held stops typematic caps makes from retoggling.
    always_comb begin
        lshift_nx_s    = lshift_r;
        rshift_nx_s    = rshift_r;
        lctrl_nx_s     = lctrl_r;
        rctrl_nx_s     = rctrl_r;
        caps_held_nx_s = caps_held_r;
        caps_nx_s      = caps_lock;
        if (complete_s) begin
            case ({comp_ext_s, keyb_data})
                {1'b0, SC_LSHIFT}: lshift_nx_s = !comp_rel_s;
                {1'b0, SC_RSHIFT}: rshift_nx_s = !comp_rel_s;
                {1'b0, SC_CTRL}:   lctrl_nx_s  = !comp_rel_s;
                {1'b1, SC_CTRL}:   rctrl_nx_s  = !comp_rel_s;
                {1'b0, SC_CAPS}: begin
                    caps_held_nx_s = !comp_rel_s;
                    if (!comp_rel_s && !caps_held_r) begin
                        caps_nx_s = !caps_lock;
                    end else begin
                        caps_nx_s = caps_lock;
                    end
                end
                default: caps_nx_s = caps_lock;
            endcase
        end else begin
            caps_nx_s = caps_lock;
        end
    end

    ps2_set2_to_ascii u_map (
        .code      (keyb_data),
        .extended  (comp_ext_s),
        .shift     (shift),
        .ascii     (map_ascii_s),
        .printable (map_printable_s),
        .is_letter (map_letter_s)
    );

    // Letter case: ctrl gives control codes, otherwise shift XOR caps selects uppercase.
    always_comb begin
        if (map_letter_s && ctrl) begin
            ascii_nx_s = map_ascii_s - 8'h60;
        end else if (map_letter_s && (shift ^ caps_lock)) begin
            ascii_nx_s = map_ascii_s - 8'h20;
        end else begin
            ascii_nx_s = map_ascii_s;
        end
    end

    assign emit_ascii_s = complete_s && !comp_rel_s && map_printable_s;

    // Registered outputs and modifier state.
    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            key_code     <= 8'h00;
            key_extended <= 1'b0;
            key_release  <= 1'b0;
            key_event    <= 1'b0;
            ascii        <= 8'h00;
            ascii_valid  <= 1'b0;
            shift        <= 1'b0;
            ctrl         <= 1'b0;
            caps_lock    <= 1'b0;
            lshift_r     <= 1'b0;
            rshift_r     <= 1'b0;
            lctrl_r      <= 1'b0;
            rctrl_r      <= 1'b0;
            caps_held_r  <= 1'b0;
        end else begin
            key_event   <= complete_s;
            ascii_valid <= emit_ascii_s;
            if (complete_s) begin
                key_code     <= keyb_data;
                key_extended <= comp_ext_s;
                key_release  <= comp_rel_s;
            end
            if (emit_ascii_s) begin
                ascii <= ascii_nx_s;
            end
            lshift_r    <= lshift_nx_s;
            rshift_r    <= rshift_nx_s;
            lctrl_r     <= lctrl_nx_s;
            rctrl_r     <= rctrl_nx_s;
            caps_held_r <= caps_held_nx_s;
            caps_lock   <= caps_nx_s;
            shift       <= lshift_nx_s | rshift_nx_s;
            ctrl        <= lctrl_nx_s | rctrl_nx_s;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected key events are queued as
// the final byte of each sequence is driven and compared when key_event fires.
module tb_ps2_scancode_decoder;

    localparam int TIMEOUT = 62500;

    logic       clk_25mhz = 1'b0;
    logic       reset_n;
    logic [7:0] keyb_data;
    logic       keyb_valid;
    logic       keyb_error;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_release;
    logic       key_event;
    logic [7:0] ascii;
    logic       ascii_valid;
    logic       shift;
    logic       ctrl;
    logic       caps_lock;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic       av;
        logic [7:0] asc;
        logic       sh;
        logic       ct;
        logic       cp;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       none;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] last_asc;

    ps2_scancode_decoder #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .PAUSE_SKIP     (7)
    ) dut (
        .clk_25mhz    (clk_25mhz),
        .reset_n      (reset_n),
        .keyb_data    (keyb_data),
        .keyb_valid   (keyb_valid),
        .keyb_error   (keyb_error),
        .key_code     (key_code),
        .key_extended (key_extended),
        .key_release  (key_release),
        .key_event    (key_event),
        .ascii        (ascii),
        .ascii_valid  (ascii_valid),
        .shift        (shift),
        .ctrl         (ctrl),
        .caps_lock    (caps_lock)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    always @(posedge clk_25mhz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] code, input logic ext, input logic rel,
                                input logic av, input logic [7:0] asc,
                                input logic sh, input logic ct, input logic cp);
        exp_t e;
        e.code = code; e.ext = ext; e.rel = rel; e.av = av; e.asc = asc;
        e.sh = sh; e.ct = ct; e.cp = cp; e.cyc = 0;
        return e;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic v, input logic er,
                             input bit push, input exp_t e);
        @(negedge clk_25mhz);
        keyb_data  = b;
        keyb_valid = v;
        keyb_error = er;
        if (push) begin
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(negedge clk_25mhz);
        keyb_valid = 1'b0;
        keyb_error = 1'b0;
        repeat (2) @(negedge clk_25mhz);
    endtask

    task automatic raw(input logic [7:0] b);
        send_byte(b, 1'b1, 1'b0, 1'b0, none);
    endtask

    task automatic key(input logic ext, input logic rel, input logic [7:0] code,
                       input logic av, input logic [7:0] asc,
                       input logic sh, input logic ct, input logic cp);
        if (ext) raw(8'hE0);
        if (rel) raw(8'hF0);
        send_byte(code, 1'b1, 1'b0, 1'b1, mk(code, ext, rel, av, asc, sh, ct, cp));
    endtask

    // Output monitor: pops one expectation per key_event.
    initial begin
        exp_t e;
        last_asc = 8'h00;
        forever begin
            @(negedge clk_25mhz);
            if (!reset_n) begin
                last_asc = 8'h00;
            end else begin
                if (ascii_valid && !key_event)
                    check("stray_ascii_valid", 32'(ascii_valid), 32'(1'b0));
                if (key_event) begin
                    if (sb.size() == 0) begin
                        check($sformatf("unexpected_event_%0h", key_code), 32'(key_event), 32'(1'b0));
                    end else begin
                        e = sb.pop_front();
                        if (e.av) last_asc = e.asc;
                        check("latency",      cyc, e.cyc + 1);
                        check("key_code",     32'(key_code),     32'(e.code));
                        check("key_extended", 32'(key_extended), 32'(e.ext));
                        check("key_release",  32'(key_release),  32'(e.rel));
                        check("ascii_valid",  32'(ascii_valid),  32'(e.av));
                        check("ascii",        32'(ascii),        32'(last_asc));
                        check("shift",        32'(shift),        32'(e.sh));
                        check("ctrl",         32'(ctrl),         32'(e.ct));
                        check("caps_lock",    32'(caps_lock),    32'(e.cp));
                    end
                end
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        keyb_data  = 8'h00;
        keyb_valid = 1'b0;
        keyb_error = 1'b0;
        repeat (3) @(negedge clk_25mhz);
        reset_n = 1'b1;
        @(negedge clk_25mhz);
        check("reset_outputs", 32'({key_code, ascii, key_extended, key_release, key_event,
                                   ascii_valid, shift, ctrl, caps_lock}), 32'h0);

        // plain make / break
        key(1'b0, 1'b0, 8'h1C, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        key(1'b0, 1'b1, 8'h1C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // left shift
        key(1'b0, 1'b0, 8'h12, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h1C, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
        key(1'b0, 1'b1, 8'h1C, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        key(1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // right shift, digits, punctuation, specials
        key(1'b0, 1'b0, 8'h59, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h16, 1'b1, 8'h21, 1'b1, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h52, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        key(1'b0, 1'b1, 8'h59, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h16, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h29, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        key(1'b1, 1'b0, 8'h4A, 1'b1, 8'h2F, 1'b0, 1'b0, 1'b0);
        key(1'b1, 1'b0, 8'h5A, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h66, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h76, 1'b1, 8'h1B, 1'b0, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h0D, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
        key(1'b1, 1'b0, 8'h75, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // caps lock, typematic repeats
        key(1'b0, 1'b0, 8'h58, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        key(1'b0, 1'b1, 8'h58, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        key(1'b0, 1'b0, 8'h1C, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
        key(1'b0, 1'b0, 8'h1C, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
        key(1'b0, 1'b1, 8'h1C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        key(1'b0, 1'b0, 8'h16, 1'b1, 8'h31, 1'b0, 1'b0, 1'b1);
        key(1'b0, 1'b0, 8'h58, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h58, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h58, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        key(1'b0, 1'b1, 8'h58, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h12, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h1C, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h58, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        key(1'b0, 1'b1, 8'h58, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        key(1'b0, 1'b0, 8'h1C, 1'b1, 8'h61, 1'b1, 1'b0, 1'b1);
        key(1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        key(1'b0, 1'b0, 8'h58, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        key(1'b0, 1'b1, 8'h58, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // ctrl, left and right
        key(1'b0, 1'b0, 8'h14, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        key(1'b0, 1'b0, 8'h21, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
        key(1'b0, 1'b0, 8'h12, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        key(1'b0, 1'b0, 8'h1A, 1'b1, 8'h1A, 1'b1, 1'b1, 1'b0);
        key(1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        key(1'b1, 1'b0, 8'h14, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        key(1'b0, 1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        key(1'b0, 1'b0, 8'h1C, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        key(1'b1, 1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // Pause sequence produces nothing
        raw(8'hE1); raw(8'h14); raw(8'h77); raw(8'hE1);
        raw(8'hF0); raw(8'h14); raw(8'hF0); raw(8'h77);
        key(1'b0, 1'b0, 8'h1C, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        // short gap inside a break: no timeout
        raw(8'hF0);
        repeat (200) @(negedge clk_25mhz);
        send_byte(8'h1C, 1'b1, 1'b0, 1'b1, mk(8'h1C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        // timeout abandons the F0 prefix
        raw(8'hF0);
        repeat (TIMEOUT + 1) @(negedge clk_25mhz);
        key(1'b0, 1'b0, 8'h1C, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        // error with a simultaneous byte, and a lone error strobe
        send_byte(8'hF0, 1'b1, 1'b1, 1'b0, none);
        key(1'b0, 1'b0, 8'h1C, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        raw(8'hF0);
        send_byte(8'h00, 1'b0, 1'b1, 1'b0, none);
        key(1'b0, 1'b0, 8'h1C, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        raw(8'hE0);
        send_byte(8'h00, 1'b0, 1'b1, 1'b0, none);
        key(1'b0, 1'b0, 8'h5A, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0);
        // reset mid-sequence with caps held
        key(1'b0, 1'b0, 8'h58, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        raw(8'hE0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk_25mhz);
        reset_n = 1'b1;
        check("midseq_reset_outputs", 32'({key_code, ascii, key_extended, key_release, key_event,
                                          ascii_valid, shift, ctrl, caps_lock}), 32'h0);
        key(1'b0, 1'b0, 8'h5A, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0);
        key(1'b0, 1'b0, 8'h58, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        key(1'b0, 1'b1, 8'h58, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        repeat (5) @(negedge clk_25mhz);
        check("pending_events", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Sits directly downstream of the PS/2 byte receiver (ps2_intf). It consumes received scan-code set 2 bytes and their valid/error strobes, and strips the E0, F0 and E1 prefixes. It tracks the shift, ctrl and caps-lock state and emits one key-event strobe per complete sequence. Printable make codes also produce an ASCII character strobe for consumers such as the UART debug printer.

Parameters:
TIMEOUT_CYCLES, 62500, clk cycles (2.5 ms) a prefix state may wait for its next byte before abandoning the sequence
PAUSE_SKIP, 7, bytes discarded after an E1 prefix (Pause key sequence)

Ports:
clk_25mhz  in  1  system clock, 25 MHz
reset_n  in  1  synchronous, active-low reset
keyb_data  in  8  received byte from PS/2 receiver
keyb_valid  in  1  one-cycle strobe: keyb_data holds a good byte
keyb_error  in  1  one-cycle strobe: receiver framing/parity error
key_code  out  8  final scan code of the last completed sequence
key_extended  out  1  last sequence carried an E0 prefix
key_release  out  1  last sequence carried an F0 prefix
key_event  out  1  one-cycle strobe: key_code/key_extended/key_release updated
ascii  out  8  ASCII of the last printable make
ascii_valid  out  1  one-cycle strobe, ascii updated
shift  out  1  left (12) or right (59) shift held
ctrl  out  1  left (14) or right (E0 14) ctrl held
caps_lock  out  1  caps-lock toggle state

Behaviour:
- Reset (sync, reset_n=0 at a clk edge): all outputs 0; FSM to IDLE; timeout and skip counters 0; internal lshift/rshift/lctrl/rctrl/caps_held cleared. Reset mid-sequence discards the partial sequence.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (E1 seen).
- IDLE: E0->EXT; F0->BRK; E1->SKIP with skip counter loaded to PAUSE_SKIP; any other byte completes a make.
- EXT: F0->EXT_BRK; E0 ignored (stay in EXT); other byte completes an extended make.
- BRK: other byte completes a break. EXT_BRK: other byte completes an extended break.
- SKIP: decrement on each valid byte; leave for IDLE after the PAUSE_SKIP-th byte. No key_event is produced for Pause.
- Completion: registered outputs, latency 1 cycle after the keyb_valid of the final byte. key_event pulses for 1 cycle and FSM returns to IDLE. ascii_valid (if any) pulses in the same cycle.
- Timeout: counter resets on each valid byte and runs in EXT/BRK/EXT_BRK/SKIP. At TIMEOUT_CYCLES it forces IDLE with no event.
- keyb_error: forces IDLE, drops any partial sequence, and produces no event. If keyb_error and keyb_valid arrive in the same cycle, error wins and the byte is dropped.
- Modifiers update in the completion cycle; the shift/ctrl outputs reflect the new state in the same cycle as key_event.
- Caps lock (58) toggles on make only when caps_held=0, then sets caps_held. Its break clears caps_held, so typematic repeats do not retoggle.
- ASCII (makes only, never breaks):
  - letters: lowercase; uppercase when shift XOR caps_lock. With ctrl held: 0x01..0x1A, ignoring shift and caps.
  - digits and punctuation: US layout, shifted symbol when shift=1; caps lock has no effect.
  - 29->0x20, 5A->0x0D, 66->0x08, 0D->0x09, 76->0x1B, E0 5A->0x0D, E0 4A->0x2F.
  - all other codes, including modifier keys: no ascii_valid.
- Typematic repeated makes each produce key_event and, if the key is printable, ascii_valid.
- ascii and key_* hold their last value between strobes.

Decomposition:
- Package ps2_pkg holds:
  - FSM state enum
  - prefix constants PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1
  - modifier codes SC_LSHIFT=12, SC_RSHIFT=59, SC_CTRL=14, SC_CAPS=58
- One sub-module, ps2_set2_to_ascii: a combinational lookup from (code, extended, shift) to {ascii, printable, is_letter}. The top applies caps-lock and ctrl rules to its output.

Test Plan:
- Bytes 1C then F0 1C -> key_event with code 1C, rel=0, ascii=0x61, ascii_valid 1 cycle after the 1C strobe; then key_event with rel=1 and no ascii_valid.
- 12, 1C, F0 1C, F0 12 -> ascii=0x41, shift=1 during the 1C make, shift=0 after F0 12.
- 58, F0 58, 1C -> caps_lock=1 and ascii=0x41. Then 58 58 58 (repeat), F0 58 -> caps_lock=0. Then 12, 1C -> ascii=0x41; and caps=1 with 12, 1C -> ascii=0x61.
- 14, 21 -> ctrl=1, ascii=0x03. Then E0 14, F0 14 -> ctrl stays 1 (right held); E0 F0 14 -> ctrl=0 with key_extended=1, key_release=1.
- E1 14 77 E1 F0 14 F0 77, then 1C -> no event for the first 8 bytes; 1C -> ascii=0x61.
- F0, idle TIMEOUT_CYCLES+1, 1C -> treated as a make with ascii=0x61. F0 with keyb_error, then 1C -> make with ascii=0x61. reset_n low after E0 -> next 5A gives ext=0 and ascii=0x0D.
